// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, miss detection, scoring and winner tracking.
// Gates ball motion through o_Game_On / o_Ball_Reset; flags decode the state register directly.
module pong_match_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_PADDLE_HEIGHT = 5,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_FRAMES  = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Game_Start,
  input  logic       i_Frame_Tick,
  input  logic [5:0] i_Ball_X,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y_P1,
  input  logic [5:0] i_Paddle_Y_P2,
  output logic       o_Game_On,
  output logic       o_Ball_Reset,
  output logic       o_Serve_Dir,
  output logic       o_Point_P1,
  output logic       o_Point_P2,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  localparam int CW = (c_SERVE_FRAMES > 1) ? $clog2(c_SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] SERVE_LAST = CW'(c_SERVE_FRAMES - 1);
  localparam logic [3:0]    LIMIT      = 4'(c_SCORE_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE      = 3'd1,
    ST_RUNNING    = 3'd2,
    ST_POINT      = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          scorer_q, scorer_d;   // 0: P1 scored, 1: P2 scored
  logic [3:0]    score_p1_q, score_p1_d;
  logic [3:0]    score_p2_q, score_p2_d;
  logic [1:0]    winner_q, winner_d;
  logic          dir_q, dir_d;
  logic          start_q;

  logic       start_edge;
  logic [6:0] y7, p1_top, p1_bot, p2_top, p2_bot;
  logic       p1_miss, p2_miss;
  logic [3:0] p1_next, p2_next;

  assign start_edge = i_Game_Start & ~start_q;

  // Span arithmetic in 7 bits so a paddle near the bottom never wraps to row 0.
  assign y7     = {1'b0, i_Ball_Y};
  assign p1_top = {1'b0, i_Paddle_Y_P1};
  assign p1_bot = p1_top + 7'(c_PADDLE_HEIGHT - 1);
  assign p2_top = {1'b0, i_Paddle_Y_P2};
  assign p2_bot = p2_top + 7'(c_PADDLE_HEIGHT - 1);
  assign p1_miss = (i_Ball_X == 6'd0) && ((y7 < p1_top) || (y7 > p1_bot));
  assign p2_miss = (i_Ball_X == 6'(c_GAME_WIDTH - 1)) && ((y7 < p2_top) || (y7 > p2_bot));

  assign p1_next = (score_p1_q < LIMIT) ? score_p1_q + 4'd1 : score_p1_q;
  assign p2_next = (score_p2_q < LIMIT) ? score_p2_q + 4'd1 : score_p2_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    scorer_d   = scorer_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    winner_d   = winner_q;
    dir_d      = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end
      ST_SERVE: begin
        if (i_Frame_Tick) begin
          if (cnt_q == SERVE_LAST) state_d = ST_RUNNING;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RUNNING: begin
        if (p1_miss) begin
          scorer_d = 1'b1;
          state_d  = ST_POINT;
        end else if (p2_miss) begin
          scorer_d = 1'b0;
          state_d  = ST_POINT;
        end
      end
      ST_POINT: begin
        dir_d = scorer_q;
        cnt_d = '0;
        if (scorer_q) begin
          score_p2_d = p2_next;
          if (p2_next == LIMIT) begin
            state_d  = ST_MATCH_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = ST_SERVE;
          end
        end else begin
          score_p1_d = p1_next;
          if (p1_next == LIMIT) begin
            state_d  = ST_MATCH_OVER;
            winner_d = 2'b01;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_MATCH_OVER: begin
        if (start_edge) begin
          score_p1_d = '0;
          score_p2_d = '0;
          winner_d   = 2'b00;
          cnt_d      = '0;
          state_d    = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      scorer_q   <= 1'b0;
      score_p1_q <= '0;
      score_p2_q <= '0;
      winner_q   <= 2'b00;
      dir_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scorer_q   <= scorer_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      winner_q   <= winner_d;
      dir_q      <= dir_d;
      start_q    <= i_Game_Start;
    end
  end

  assign o_Game_On    = (state_q == ST_RUNNING);
  assign o_Ball_Reset = (state_q != ST_RUNNING);
  assign o_Point_P1   = (state_q == ST_POINT) && !scorer_q;
  assign o_Point_P2   = (state_q == ST_POINT) &&  scorer_q;
  assign o_Serve_Dir  = dir_q;
  assign o_Score_P1   = score_p1_q;
  assign o_Score_P2   = score_p2_q;
  assign o_Winner     = winner_q;
  assign o_State      = state_q;

endmodule
